// File: rtl/sata_link_rx_ctrl.sv
// sata_link_rx_ctrl: SATA link-layer receive sequencer.
// Decodes the received primitive/data stream and drives the RX datapath
// through a one-dword hold buffer, so the CRC dword is tagged with rx_eop.
// It also picks the handshake primitive the TX side should send.
// Optional build macro: SATA_LINK_RX_CTRL_CNT_EN adds saturating frame
// statistics outputs (cnt_good, cnt_bad, cnt_abort).
module sata_link_rx_ctrl #(
  parameter int STAT_TIMEOUT     = 16,
  parameter int MAX_FRAME_DWORDS = 2049
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        link_up,
  input  logic [31:0] in_dat,
  input  logic        in_val,
  input  logic [3:0]  in_prim,
  output logic [31:0] rx_dat,
  output logic        rx_val,
  output logic        rx_eop,
  input  logic        fifo_almostfull,
  input  logic        stat_good_crc,
  input  logic        stat_bad_crc,
  input  logic        stat_fifo_ovfl,
  output logic [3:0]  tx_prim,
  output logic        frm_busy,
  output logic        frm_abort
`ifdef SATA_LINK_RX_CTRL_CNT_EN
  ,
  output logic [15:0] cnt_good,
  output logic [15:0] cnt_bad,
  output logic [15:0] cnt_abort
`endif
);

  typedef enum logic [3:0] {
    P_DATA  = 4'd0,  P_SYNC  = 4'd1,  P_X_RDY = 4'd2,  P_R_RDY = 4'd3,
    P_SOF   = 4'd4,  P_EOF   = 4'd5,  P_HOLD  = 4'd6,  P_HOLDA = 4'd7,
    P_R_IP  = 4'd8,  P_R_OK  = 4'd9,  P_R_ERR = 4'd10, P_WTRM  = 4'd11
  } prim_e;

  typedef enum logic [2:0] {
    S_IDLE, S_RDY, S_RECV, S_STATW, S_GOOD, S_BAD
  } state_e;

  localparam int                TCNT_W    = $clog2(STAT_TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(STAT_TIMEOUT - 1);
  localparam logic [11:0]       MAX_DW    = 12'(MAX_FRAME_DWORDS);

  state_e            r_state, w_state_nx;
  logic [31:0]       r_buf, w_buf_nx;
  logic              r_buf_full, w_buf_full_nx;
  logic [11:0]       r_dw_cnt, w_dw_cnt_nx, w_dw_cnt_inc;
  logic              r_err, w_err_nx, w_err_now;
  logic [TCNT_W-1:0] r_tcnt, w_tcnt_nx;
  logic              r_peer_hold, w_peer_hold_nx;
  logic [31:0]       r_rx_dat, w_rx_dat_nx;
  logic              r_rx_val, r_rx_eop, r_abort, r_busy;
  logic [3:0]        r_tx_prim, w_tx_nx;
  logic              w_emit, w_eop, w_abort, w_busy_nx;

  assign w_dw_cnt_inc = (r_dw_cnt == 12'hFFF) ? r_dw_cnt : r_dw_cnt + 12'd1;
  assign w_err_now    = r_err | stat_fifo_ovfl;

  // Next-state, hold-buffer and frame bookkeeping for one received dword.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_state_nx     = r_state;
    w_buf_nx       = r_buf;
    w_buf_full_nx  = r_buf_full;
    w_dw_cnt_nx    = r_dw_cnt;
    w_err_nx       = r_err;
    w_tcnt_nx      = r_tcnt;
    w_peer_hold_nx = r_peer_hold;
    w_emit         = 1'b0;
    w_eop          = 1'b0;
    w_abort        = 1'b0;
    w_rx_dat_nx    = r_rx_dat;

    if (!link_up) begin
      // Link loss: close any open frame towards the CRC checker, then idle.
      w_abort = r_busy;
      if (r_buf_full) begin
        w_emit = 1'b1;
        w_eop  = 1'b1;
      end
      w_state_nx     = S_IDLE;
      w_buf_nx       = '0;
      w_buf_full_nx  = 1'b0;
      w_dw_cnt_nx    = '0;
      w_err_nx       = 1'b0;
      w_tcnt_nx      = '0;
      w_peer_hold_nx = 1'b0;
      w_rx_dat_nx    = r_buf_full ? r_buf : 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_val && in_prim == P_X_RDY) begin
            w_state_nx = S_RDY;
            w_err_nx   = 1'b0;
          end
        end
        S_RDY: begin
          if (in_val && in_prim == P_SOF) begin
            w_state_nx     = S_RECV;
            w_buf_full_nx  = 1'b0;
            w_dw_cnt_nx    = '0;
            w_peer_hold_nx = 1'b0;
          end else if (in_val && in_prim == P_SYNC) begin
            w_state_nx = S_IDLE;
          end
        end
        S_RECV: begin
          if (stat_fifo_ovfl) w_err_nx = 1'b1;
          if (in_val) begin
            w_peer_hold_nx = (in_prim == P_HOLD);
            case (in_prim)
              P_DATA: begin
                // The newest dword is always held back: it may be the CRC.
                w_emit        = r_buf_full;
                w_buf_nx      = in_dat;
                w_buf_full_nx = 1'b1;
                w_dw_cnt_nx   = w_dw_cnt_inc;
                if (w_dw_cnt_inc > MAX_DW) w_err_nx = 1'b1;
              end
              P_EOF: begin
                if (r_buf_full) begin
                  w_emit = 1'b1;
                  w_eop  = 1'b1;
                end else begin
                  w_err_nx = 1'b1;
                end
                w_buf_full_nx = 1'b0;
                w_tcnt_nx     = '0;
                w_state_nx    = S_STATW;
              end
              P_SYNC, P_WTRM: begin
                // Peer gave up on the frame; still close it in the RX path.
                if (r_buf_full) begin
                  w_emit = 1'b1;
                  w_eop  = 1'b1;
                end
                w_buf_full_nx = 1'b0;
                w_abort       = (in_prim == P_SYNC);
                w_state_nx    = (in_prim == P_SYNC) ? S_IDLE : S_BAD;
              end
              default: ;
            endcase
          end
        end
        S_STATW: begin
          w_err_nx  = w_err_now;
          w_tcnt_nx = r_tcnt + TCNT_W'(1);
          // A status pulse on the timeout clock still decides the outcome.
          if (stat_bad_crc || w_err_now) w_state_nx = S_BAD;
          else if (stat_good_crc)        w_state_nx = S_GOOD;
          else if (r_tcnt == TCNT_LAST)  w_state_nx = S_BAD;
        end
        S_GOOD, S_BAD: begin
          if (in_val && in_prim == P_SYNC) w_state_nx = S_IDLE;
        end
        default: w_state_nx = S_IDLE;
      endcase
      if (w_emit) w_rx_dat_nx = r_buf;
    end
  end

  // Primitive request and busy flag for the state being entered.
  always_comb begin
    w_tx_nx = P_SYNC;
    case (w_state_nx)
      S_IDLE:  w_tx_nx = P_SYNC;
      S_RDY:   w_tx_nx = P_R_RDY;
      S_RECV:  w_tx_nx = fifo_almostfull ? P_HOLD : (w_peer_hold_nx ? P_HOLDA : P_R_IP);
      S_STATW: w_tx_nx = P_R_IP;
      S_GOOD:  w_tx_nx = P_R_OK;
      S_BAD:   w_tx_nx = P_R_ERR;
      default: w_tx_nx = P_SYNC;
    endcase
    w_busy_nx = (w_state_nx inside {S_RECV, S_STATW, S_GOOD, S_BAD});
  end

  // State and registered outputs; reset has priority over everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      r_state     <= S_IDLE;
      r_buf       <= '0;
      r_buf_full  <= 1'b0;
      r_dw_cnt    <= '0;
      r_err       <= 1'b0;
      r_tcnt      <= '0;
      r_peer_hold <= 1'b0;
      r_rx_dat    <= '0;
      r_rx_val    <= 1'b0;
      r_rx_eop    <= 1'b0;
      r_tx_prim   <= P_SYNC;
      r_busy      <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_buf       <= w_buf_nx;
      r_buf_full  <= w_buf_full_nx;
      r_dw_cnt    <= w_dw_cnt_nx;
      r_err       <= w_err_nx;
      r_tcnt      <= w_tcnt_nx;
      r_peer_hold <= w_peer_hold_nx;
      r_rx_dat    <= w_rx_dat_nx;
      r_rx_val    <= w_emit;
      r_rx_eop    <= w_eop;
      r_tx_prim   <= w_tx_nx;
      r_busy      <= w_busy_nx;
      r_abort     <= w_abort;
    end
  end

  assign rx_dat    = r_rx_dat;
  assign rx_val    = r_rx_val;
  assign rx_eop    = r_rx_eop;
  assign tx_prim   = r_tx_prim;
  assign frm_busy  = r_busy;
  assign frm_abort = r_abort;

`ifdef SATA_LINK_RX_CTRL_CNT_EN
  logic [15:0] r_cnt_good, r_cnt_bad, r_cnt_abort;

  // Saturating statistics: entries into GOOD/BAD and abort pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_good  <= '0;
      r_cnt_bad   <= '0;
      r_cnt_abort <= '0;
    end else begin
      if (w_state_nx == S_GOOD && r_state != S_GOOD && r_cnt_good != 16'hFFFF)
        r_cnt_good <= r_cnt_good + 16'd1;
      if (w_state_nx == S_BAD && r_state != S_BAD && r_cnt_bad != 16'hFFFF)
        r_cnt_bad <= r_cnt_bad + 16'd1;
      if (w_abort && r_cnt_abort != 16'hFFFF)
        r_cnt_abort <= r_cnt_abort + 16'd1;
    end
  end

  assign cnt_good  = r_cnt_good;
  assign cnt_bad   = r_cnt_bad;
  assign cnt_abort = r_cnt_abort;
`endif

endmodule

// File: tb/tb_sata_link_rx_ctrl.sv
// Self-checking bench for sata_link_rx_ctrl: explicit vector table for a
// clean frame, hand-written corner sequences, and randomized traffic, all
// compared every clock against a frame-level reference model.
`timescale 1ns/1ps
module tb_sata_link_rx_ctrl;
  localparam int STAT_TIMEOUT     = 16;
  localparam int MAX_FRAME_DWORDS = 2049;

  localparam logic [3:0] PR_DATA = 4'd0, PR_SYNC = 4'd1, PR_X_RDY = 4'd2, PR_R_RDY = 4'd3,
                         PR_SOF = 4'd4, PR_EOF = 4'd5, PR_HOLD = 4'd6, PR_HOLDA = 4'd7,
                         PR_R_IP = 4'd8, PR_R_OK = 4'd9, PR_R_ERR = 4'd10, PR_WTRM = 4'd11;

  logic        clk = 1'b0;
  logic        reset, link_up, in_val, fifo_almostfull;
  logic        stat_good_crc, stat_bad_crc, stat_fifo_ovfl;
  logic [31:0] in_dat;
  logic [3:0]  in_prim;
  logic [31:0] rx_dat;
  logic        rx_val, rx_eop, frm_busy, frm_abort;
  logic [3:0]  tx_prim;
`ifdef SATA_LINK_RX_CTRL_CNT_EN
  logic [15:0] cnt_good, cnt_bad, cnt_abort;
`endif

  int n_checks = 0;
  int n_errors = 0;

  sata_link_rx_ctrl #(.STAT_TIMEOUT(STAT_TIMEOUT), .MAX_FRAME_DWORDS(MAX_FRAME_DWORDS)) dut (
    .clk(clk), .reset(reset), .link_up(link_up), .in_dat(in_dat), .in_val(in_val),
    .in_prim(in_prim), .rx_dat(rx_dat), .rx_val(rx_val), .rx_eop(rx_eop),
    .fifo_almostfull(fifo_almostfull), .stat_good_crc(stat_good_crc),
    .stat_bad_crc(stat_bad_crc), .stat_fifo_ovfl(stat_fifo_ovfl),
    .tx_prim(tx_prim), .frm_busy(frm_busy), .frm_abort(frm_abort)
`ifdef SATA_LINK_RX_CTRL_CNT_EN
    , .cnt_good(cnt_good), .cnt_bad(cnt_bad), .cnt_abort(cnt_abort)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model (frame-level view) ----------------
  typedef enum {PH_IDLE, PH_READY, PH_FRAME, PH_WAIT, PH_OK, PH_ERR} phase_t;
  phase_t      m_phase = PH_IDLE;
  logic [31:0] m_q[$];
  int          m_ndw, m_waited;
  bit          m_err, m_peer_hold;
  logic [3:0]  m_tx = PR_SYNC;
  logic [31:0] m_dat = '0;
  bit          m_val, m_eop, m_busy, m_abort;
  int          m_cnt_good, m_cnt_bad, m_cnt_abort;

  task automatic m_close();
    if (m_q.size() > 0) begin
      m_val = 1; m_eop = 1; m_dat = m_q.pop_front();
    end
    m_q.delete();
  endtask

  task automatic model_step();
    phase_t prev = m_phase;
    m_val = 0; m_eop = 0; m_abort = 0;
    if (reset) begin
      m_phase = PH_IDLE; m_q.delete(); m_ndw = 0; m_err = 0; m_waited = 0;
      m_peer_hold = 0; m_dat = '0;
      m_cnt_good = 0; m_cnt_bad = 0; m_cnt_abort = 0;
    end else if (!link_up) begin
      m_abort = m_busy;
      if (m_q.size() > 0) m_close(); else m_dat = '0;
      m_phase = PH_IDLE; m_ndw = 0; m_err = 0; m_waited = 0; m_peer_hold = 0;
    end else begin
      case (m_phase)
        PH_IDLE:  if (in_val && in_prim == PR_X_RDY) begin m_phase = PH_READY; m_err = 0; end
        PH_READY: if (in_val && in_prim == PR_SOF) begin
                    m_phase = PH_FRAME; m_q.delete(); m_ndw = 0; m_peer_hold = 0;
                  end else if (in_val && in_prim == PR_SYNC) m_phase = PH_IDLE;
        PH_FRAME: begin
          if (stat_fifo_ovfl) m_err = 1;
          if (in_val) begin
            m_peer_hold = (in_prim == PR_HOLD);
            if (in_prim == PR_DATA) begin
              m_ndw++;
              if (m_ndw > MAX_FRAME_DWORDS) m_err = 1;
              if (m_q.size() > 0) begin m_val = 1; m_dat = m_q.pop_front(); end
              m_q.push_back(in_dat);
            end else if (in_prim == PR_EOF) begin
              if (m_q.size() == 0) m_err = 1;
              m_close();
              m_phase = PH_WAIT; m_waited = 0;
            end else if (in_prim == PR_SYNC) begin
              m_abort = 1; m_close(); m_phase = PH_IDLE;
            end else if (in_prim == PR_WTRM) begin
              m_close(); m_phase = PH_ERR;
            end
          end
        end
        PH_WAIT: begin
          m_waited++;
          if (stat_fifo_ovfl) m_err = 1;
          if (stat_bad_crc || m_err)        m_phase = PH_ERR;
          else if (stat_good_crc)           m_phase = PH_OK;
          else if (m_waited >= STAT_TIMEOUT) m_phase = PH_ERR;
        end
        default: if (in_val && in_prim == PR_SYNC) m_phase = PH_IDLE;
      endcase
    end
    if (!reset) begin
      if (m_phase == PH_OK  && prev != PH_OK  && m_cnt_good  < 65535) m_cnt_good++;
      if (m_phase == PH_ERR && prev != PH_ERR && m_cnt_bad   < 65535) m_cnt_bad++;
      if (m_abort && m_cnt_abort < 65535) m_cnt_abort++;
    end
    case (m_phase)
      PH_READY: m_tx = PR_R_RDY;
      PH_FRAME: m_tx = fifo_almostfull ? PR_HOLD : (m_peer_hold ? PR_HOLDA : PR_R_IP);
      PH_WAIT:  m_tx = PR_R_IP;
      PH_OK:    m_tx = PR_R_OK;
      PH_ERR:   m_tx = PR_R_ERR;
      default:  m_tx = PR_SYNC;
    endcase
    m_busy = (m_phase != PH_IDLE && m_phase != PH_READY);
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Advance one clock with the current inputs; compare against the model.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("tx_prim", tx_prim, m_tx);
    check("rx_val", rx_val, m_val);
    check("rx_eop", rx_eop, m_eop);
    check("rx_dat", rx_dat, m_dat);
    check("frm_busy", frm_busy, m_busy);
    check("frm_abort", frm_abort, m_abort);
  endtask

  task automatic send(input logic [3:0] p, input logic [31:0] d);
    in_val = 1'b1; in_prim = p; in_dat = d;
    tick();
    in_val = 1'b0; in_prim = PR_DATA; in_dat = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic stat_pulse(input bit good, input bit bad);
    stat_good_crc = good; stat_bad_crc = bad;
    tick();
    stat_good_crc = 1'b0; stat_bad_crc = 1'b0;
  endtask

  // Frame of n data dwords (last one is the CRC), good status right after EOF.
  task automatic frame_len(input int n, input logic [3:0] exp_tx, input string name);
    send(PR_X_RDY, 0);
    send(PR_SOF, 0);
    for (int i = 0; i < n; i++) send(PR_DATA, $urandom);
    send(PR_EOF, 0);
    check({name, "_eop"}, rx_eop, 1'b1);
    stat_pulse(1'b1, 1'b0);
    check(name, tx_prim, exp_tx);
    send(PR_SYNC, 0);
  endtask

  typedef struct {
    logic        vld;
    logic [3:0]  prim;
    logic [31:0] dat;
    logic        good;
    logic [3:0]  e_tx;
    logic        e_val;
    logic        e_eop;
    logic [31:0] e_dat;
    logic        e_busy;
  } vec_t;

  vec_t tbl[12];

  localparam logic [31:0] DA = 32'hA0A0_0001, DB = 32'hB0B0_0002,
                          DC = 32'hC0C0_0003, DD = 32'hD0D0_0004;

  initial begin
    // Clean frame: X_RDY, SOF, A..D, EOF, good status 3 clocks later, SYNC.
    tbl[0]  = '{1'b1, PR_X_RDY, 32'h0, 1'b0, PR_R_RDY, 1'b0, 1'b0, 32'h0, 1'b0};
    tbl[1]  = '{1'b1, PR_SOF,   32'h0, 1'b0, PR_R_IP,  1'b0, 1'b0, 32'h0, 1'b1};
    tbl[2]  = '{1'b1, PR_DATA,  DA,    1'b0, PR_R_IP,  1'b0, 1'b0, 32'h0, 1'b1};
    tbl[3]  = '{1'b1, PR_DATA,  DB,    1'b0, PR_R_IP,  1'b1, 1'b0, DA,    1'b1};
    tbl[4]  = '{1'b1, PR_DATA,  DC,    1'b0, PR_R_IP,  1'b1, 1'b0, DB,    1'b1};
    tbl[5]  = '{1'b1, PR_DATA,  DD,    1'b0, PR_R_IP,  1'b1, 1'b0, DC,    1'b1};
    tbl[6]  = '{1'b1, PR_EOF,   32'h0, 1'b0, PR_R_IP,  1'b1, 1'b1, DD,    1'b1};
    tbl[7]  = '{1'b0, PR_DATA,  32'h0, 1'b0, PR_R_IP,  1'b0, 1'b0, 32'h0, 1'b1};
    tbl[8]  = '{1'b0, PR_DATA,  32'h0, 1'b0, PR_R_IP,  1'b0, 1'b0, 32'h0, 1'b1};
    tbl[9]  = '{1'b0, PR_DATA,  32'h0, 1'b1, PR_R_OK,  1'b0, 1'b0, 32'h0, 1'b1};
    tbl[10] = '{1'b0, PR_DATA,  32'h0, 1'b0, PR_R_OK,  1'b0, 1'b0, 32'h0, 1'b1};
    tbl[11] = '{1'b1, PR_SYNC,  32'h0, 1'b0, PR_SYNC,  1'b0, 1'b0, 32'h0, 1'b0};

    reset = 1'b1; link_up = 1'b1; in_val = 1'b0; in_prim = PR_DATA; in_dat = '0;
    fifo_almostfull = 1'b0; stat_good_crc = 1'b0; stat_bad_crc = 1'b0; stat_fifo_ovfl = 1'b0;
    idle(2);
    check("rst_tx", tx_prim, PR_SYNC);
    check("rst_val", rx_val, 1'b0);
    check("rst_dat", rx_dat, 32'h0);
    check("rst_busy", frm_busy, 1'b0);
    reset = 1'b0;
    idle(1);

    // Table-driven clean frame.
    for (int i = 0; i < 12; i++) begin
      in_val = tbl[i].vld; in_prim = tbl[i].prim; in_dat = tbl[i].dat;
      stat_good_crc = tbl[i].good;
      tick();
      check($sformatf("tbl%0d_tx", i), tx_prim, tbl[i].e_tx);
      check($sformatf("tbl%0d_val", i), rx_val, tbl[i].e_val);
      check($sformatf("tbl%0d_eop", i), rx_eop, tbl[i].e_eop);
      check($sformatf("tbl%0d_busy", i), frm_busy, tbl[i].e_busy);
      if (tbl[i].e_val) check($sformatf("tbl%0d_dat", i), rx_dat, tbl[i].e_dat);
    end
    in_val = 1'b0; stat_good_crc = 1'b0;

    // Bad CRC: R_ERR until SYNC, busy drops right after SYNC.
    send(PR_X_RDY, 0); send(PR_SOF, 0);
    send(PR_DATA, DA); send(PR_DATA, DB); send(PR_DATA, DC); send(PR_DATA, DD);
    send(PR_EOF, 0); idle(2);
    stat_pulse(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("bad_tx", tx_prim, PR_R_ERR);
      tick();
    end
    check("bad_busy", frm_busy, 1'b1);
    send(PR_SYNC, 0);
    check("bad_sync_busy", frm_busy, 1'b0);
    check("bad_sync_tx", tx_prim, PR_SYNC);

    // Flow control: own HOLD for 5 clocks, then HOLDA while peer holds.
    send(PR_X_RDY, 0); send(PR_SOF, 0); send(PR_DATA, DA); send(PR_DATA, DB);
    fifo_almostfull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(PR_HOLD, 0);
      check("hold_tx", tx_prim, PR_HOLD);
    end
    fifo_almostfull = 1'b0;
    for (int i = 0; i < 2; i++) begin
      send(PR_HOLD, 0);
      check("holda_tx", tx_prim, PR_HOLDA);
    end
    send(PR_DATA, DC);
    check("hold_rip", tx_prim, PR_R_IP);
    check("hold_dat", rx_dat, DB);
    send(PR_DATA, DD); send(PR_EOF, 0);
    check("hold_last", rx_dat, DD);
    stat_pulse(1'b1, 1'b0); send(PR_SYNC, 0);

    // Abort by SYNC after three dwords: C closes the frame with eop.
    send(PR_X_RDY, 0); send(PR_SOF, 0); send(PR_DATA, DA); send(PR_DATA, DB);
    send(PR_DATA, DC);
    send(PR_SYNC, 0);
    check("abort_val", rx_val, 1'b1);
    check("abort_eop", rx_eop, 1'b1);
    check("abort_dat", rx_dat, DC);
    check("abort_pulse", frm_abort, 1'b1);
    check("abort_tx", tx_prim, PR_SYNC);
    idle(1);
    check("abort_once", frm_abort, 1'b0);

    // Status timeout: 16 clocks of R_IP after EOF, then R_ERR.
    send(PR_X_RDY, 0); send(PR_SOF, 0); send(PR_DATA, DA); send(PR_EOF, 0);
    check("to_eop_dat", rx_dat, DA);
    for (int i = 0; i < STAT_TIMEOUT - 1; i++) begin
      tick();
      check("to_wait_tx", tx_prim, PR_R_IP);
    end
    tick();
    check("to_expire_tx", tx_prim, PR_R_ERR);
    send(PR_SYNC, 0);

    // Good status on the timeout clock itself wins.
    send(PR_X_RDY, 0); send(PR_SOF, 0); send(PR_DATA, DA); send(PR_EOF, 0);
    idle(STAT_TIMEOUT - 1);
    stat_pulse(1'b1, 1'b0);
    check("to_edge_tx", tx_prim, PR_R_OK);
    send(PR_SYNC, 0);

    // Both status pulses together count as bad.
    send(PR_X_RDY, 0); send(PR_SOF, 0); send(PR_DATA, DA); send(PR_EOF, 0);
    stat_pulse(1'b1, 1'b1);
    check("both_tx", tx_prim, PR_R_ERR);
    send(PR_SYNC, 0);

    // Zero-length frame: no data out, error.
    send(PR_X_RDY, 0); send(PR_SOF, 0); send(PR_EOF, 0);
    check("zlen_val", rx_val, 1'b0);
    stat_pulse(1'b1, 1'b0);
    check("zlen_tx", tx_prim, PR_R_ERR);
    send(PR_SYNC, 0);

    // Frame length limit.
    frame_len(MAX_FRAME_DWORDS, PR_R_OK, "len_max");
    frame_len(MAX_FRAME_DWORDS + 1, PR_R_ERR, "len_over");

    // Synchronous reset mid-frame, then a fresh X_RDY.
    send(PR_X_RDY, 0); send(PR_SOF, 0); send(PR_DATA, DA); send(PR_DATA, DB);
    reset = 1'b1; in_val = 1'b1; in_prim = PR_DATA; in_dat = DC;
    tick();
    reset = 1'b0; in_val = 1'b0;
    check("mrst_tx", tx_prim, PR_SYNC);
    check("mrst_val", rx_val, 1'b0);
    check("mrst_eop", rx_eop, 1'b0);
    check("mrst_dat", rx_dat, 32'h0);
    check("mrst_busy", frm_busy, 1'b0);
    check("mrst_abort", frm_abort, 1'b0);
    send(PR_X_RDY, 0);
    check("mrst_xrdy", tx_prim, PR_R_RDY);
    send(PR_SYNC, 0);

    // Link loss mid-frame aborts and closes the frame.
    send(PR_X_RDY, 0); send(PR_SOF, 0); send(PR_DATA, DA); send(PR_DATA, DB);
    link_up = 1'b0;
    tick();
    link_up = 1'b1;
    check("ldn_abort", frm_abort, 1'b1);
    check("ldn_eop", rx_eop, 1'b1);
    check("ldn_dat", rx_dat, DB);
    check("ldn_tx", tx_prim, PR_SYNC);

    // Randomized traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      reset           = ($urandom_range(0, 499) == 0);
      link_up         = ($urandom_range(0, 199) != 0);
      in_val          = ($urandom_range(0, 9) < 8);
      in_prim         = ($urandom_range(0, 1) == 0) ? PR_DATA : 4'($urandom_range(0, 11));
      in_dat          = $urandom;
      fifo_almostfull = ($urandom_range(0, 4) == 0);
      stat_good_crc   = ($urandom_range(0, 14) == 0);
      stat_bad_crc    = ($urandom_range(0, 19) == 0);
      stat_fifo_ovfl  = ($urandom_range(0, 49) == 0);
      tick();
    end
    reset = 1'b0; link_up = 1'b1; in_val = 1'b0; fifo_almostfull = 1'b0;
    stat_good_crc = 1'b0; stat_bad_crc = 1'b0; stat_fifo_ovfl = 1'b0;
    idle(2);

`ifdef SATA_LINK_RX_CTRL_CNT_EN
    check("cnt_good", cnt_good, 16'(m_cnt_good));
    check("cnt_bad", cnt_bad, 16'(m_cnt_bad));
    check("cnt_abort", cnt_abort, 16'(m_cnt_abort));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
